// File: rtl/seg7_display_sched_if.sv
// Bundle between the CPU debug taps, the display scheduler and the 7-segment driver.
interface seg7_display_sched_if;
    logic [127:0] src_data;
    logic [3:0]   src_valid;
    logic         mode_manual;
    logic         page_next;
    logic         freeze;
    logic         alert_req;
    logic [31:0]  alert_data;
    logic         alert_ack;
    logic [31:0]  disp_data;
    logic [2:0]   disp_src;
    logic         disp_upd;

    // Master drives the debug sources and controls; it observes the display word.
    modport master (
        output src_data, src_valid, mode_manual, page_next, freeze, alert_req, alert_data,
        input  alert_ack, disp_data, disp_src, disp_upd
    );

    // Slave is the scheduler itself.
    modport slave (
        input  src_data, src_valid, mode_manual, page_next, freeze, alert_req, alert_data,
        output alert_ack, disp_data, disp_src, disp_upd
    );
endinterface

// File: rtl/seg7_display_sched.sv
// Chooses which 32-bit debug word feeds the 8-digit 7-segment driver: timed rotation,
// manual paging, freeze, and a pre-empting alert word held for a minimum time.
module seg7_display_sched #(
    parameter int unsigned DWELL     = 50_000_000,
    parameter int unsigned ALERT_MIN = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_display_sched_if.slave   bus
);

    localparam logic [1:0]  ST_AUTO    = 2'd0;
    localparam logic [1:0]  ST_MANUAL  = 2'd1;
    localparam logic [1:0]  ST_ALERT   = 2'd2;
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam logic [31:0] ALERT_LAST = 32'(ALERT_MIN - 1);
    localparam logic [2:0]  SRC_ALERT  = 3'd4;
    localparam logic [2:0]  SRC_NONE   = 3'd7;

    logic [1:0]  st_q, st_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] dwell_q, dwell_d;
    logic [31:0] alert_cnt_q, alert_cnt_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic [2:0]  disp_src_q, disp_src_d;
    logic        disp_upd_q, disp_upd_d;
    logic        alert_ack_q, alert_ack_d;

    logic [1:0]  nxt_sel;
    logic [1:0]  cand;
    logic        any_valid;
    logic [1:0]  show_idx;
    logic [2:0]  show_src;
    logic [31:0] show_data;
    logic [1:0]  mode_st;

    // next(sel) search plus the word that should be on the display this cycle.
    // An invalid sel is never shown: the display jumps straight to the source sel moves to.
    always_comb begin
        nxt_sel = sel_q;
        cand    = '0;
        for (int k = 3; k >= 1; k--) begin
            cand = sel_q + 2'(k);
            if (bus.src_valid[cand]) begin
                nxt_sel = cand;
            end
        end
        any_valid = |bus.src_valid;
        show_idx  = bus.src_valid[sel_q] ? sel_q : nxt_sel;
        show_src  = any_valid ? {1'b0, show_idx} : SRC_NONE;
        show_data = any_valid ? bus.src_data[{show_idx, 5'b0} +: 32] : 32'd0;
        mode_st   = bus.mode_manual ? ST_MANUAL : ST_AUTO;
    end

    // Mode sequencing, selection, counters and the registered display word.
    always_comb begin
        st_d        = st_q;
        sel_d       = sel_q;
        dwell_d     = dwell_q;
        alert_cnt_d = alert_cnt_q;
        disp_data_d = disp_data_q;
        disp_src_d  = disp_src_q;
        alert_ack_d = 1'b0;

        if (st_q != ST_ALERT && bus.alert_req) begin
            // Alert entry pre-empts everything else this cycle, freeze included.
            st_d        = ST_ALERT;
            alert_cnt_d = '0;
            disp_data_d = bus.alert_data;
            disp_src_d  = SRC_ALERT;
            alert_ack_d = 1'b1;
        end else if (st_q == ST_ALERT) begin
            if (alert_cnt_q != '1) begin
                alert_cnt_d = alert_cnt_q + 32'd1;
            end
            if (alert_cnt_q >= ALERT_LAST && !bus.alert_req) begin
                st_d        = mode_st;
                dwell_d     = '0;
                disp_src_d  = show_src;
                disp_data_d = show_data;
            end
        end else begin
            st_d = mode_st;
            if (!bus.freeze) begin
                disp_src_d  = show_src;
                disp_data_d = show_data;
                if (!any_valid) begin
                    dwell_d = '0;
                end else if (!bus.src_valid[sel_q]) begin
                    sel_d   = nxt_sel;
                    dwell_d = '0;
                end else if (st_q == ST_AUTO) begin
                    if (dwell_q >= DWELL_LAST) begin
                        sel_d   = nxt_sel;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 32'd1;
                    end
                end else begin
                    dwell_d = '0;
                    if (bus.page_next) begin
                        sel_d = nxt_sel;
                    end
                end
            end
            if (st_d != st_q) begin
                dwell_d = '0;
            end
        end

        disp_upd_d = (disp_src_d != disp_src_q) || alert_ack_d;
    end

    // State registers; reset also aborts any alert in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_AUTO;
            sel_q       <= '0;
            dwell_q     <= '0;
            alert_cnt_q <= '0;
            disp_data_q <= '0;
            disp_src_q  <= SRC_NONE;
            disp_upd_q  <= 1'b0;
            alert_ack_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            sel_q       <= sel_d;
            dwell_q     <= dwell_d;
            alert_cnt_q <= alert_cnt_d;
            disp_data_q <= disp_data_d;
            disp_src_q  <= disp_src_d;
            disp_upd_q  <= disp_upd_d;
            alert_ack_q <= alert_ack_d;
        end
    end

    assign bus.disp_data = disp_data_q;
    assign bus.disp_src  = disp_src_q;
    assign bus.disp_upd  = disp_upd_q;
    assign bus.alert_ack = alert_ack_q;

endmodule

// File: tb/tb_seg7_display_sched.sv
// Bench for seg7_display_sched with DWELL=4, ALERT_MIN=3.
module tb_seg7_display_sched;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] data;
        logic        upd;
        logic        ack;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];

    seg7_display_sched_if bus ();

    seg7_display_sched #(
        .DWELL     (4),
        .ALERT_MIN (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [1:0] i);
        return 32'h5EC0_0000 | {30'd0, i};
    endfunction

    function automatic exp_t mk(input logic [2:0] s, input logic [31:0] d, input logic u,
                                input logic a);
        exp_t e;
        e.src  = s;
        e.data = d;
        e.upd  = u;
        e.ack  = a;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] valid, input logic manual);
        bus.src_data    = {word(2'd3), word(2'd2), word(2'd1), word(2'd0)};
        bus.src_valid   = valid;
        bus.mode_manual = manual;
        bus.page_next   = 1'b0;
        bus.freeze      = 1'b0;
        bus.alert_req   = 1'b0;
        bus.alert_data  = 32'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(4'b1111, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !== {3'd7, 32'd0, 2'b00})
        begin
            errors++;
            $display("FAIL reset: got src=%0d data=%h upd=%b ack=%b, want src=7 data=0 upd=0 ack=0",
                     bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_auto_rotate();
        exp_t e;
        apply_reset(4'b1111, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            e = mk(3'(((k - 1) / 4) % 4), word(2'(((k - 1) / 4) % 4)), ((k - 1) % 4) == 0, 1'b0);
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL auto_rotate cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
    endtask

    task automatic test_manual_paging();
        exp_t e;
        apply_reset(4'b1010, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            bus.page_next = (k == 3 || k == 5);
            bus.src_valid = (k >= 7) ? 4'b0000 : 4'b1010;
            case (k)
                1:       e = mk(3'd1, word(2'd1), 1'b1, 1'b0);
                2, 3:    e = mk(3'd1, word(2'd1), 1'b0, 1'b0);
                4:       e = mk(3'd3, word(2'd3), 1'b1, 1'b0);
                5:       e = mk(3'd3, word(2'd3), 1'b0, 1'b0);
                6:       e = mk(3'd1, word(2'd1), 1'b1, 1'b0);
                7:       e = mk(3'd7, 32'd0, 1'b1, 1'b0);
                default: e = mk(3'd7, 32'd0, 1'b0, 1'b0);
            endcase
            sb.push_back(e);
            tick();
            bus.page_next = 1'b0;
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL manual_paging cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
    endtask

    task automatic test_live_data();
        exp_t e;
        apply_reset(4'b1111, 1'b1);
        bus.src_data[31:0] = 32'h0000_1234;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) bus.src_data[31:0] = 32'h0000_DEAD;
            e = mk(3'd0, (k >= 3) ? 32'h0000_DEAD : 32'h0000_1234, k == 1, 1'b0);
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL live_data cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
    endtask

    task automatic test_alert_freeze();
        exp_t e;
        apply_reset(4'b1111, 1'b0);
        bus.alert_data = 32'hBADC_0DE0;
        for (int k = 1; k <= 12; k++) begin
            bus.freeze    = (k >= 6);
            bus.alert_req = (k == 8);
            case (k)
                1:        e = mk(3'd0, word(2'd0), 1'b1, 1'b0);
                2, 3, 4:  e = mk(3'd0, word(2'd0), 1'b0, 1'b0);
                5:        e = mk(3'd1, word(2'd1), 1'b1, 1'b0);
                6, 7:     e = mk(3'd1, word(2'd1), 1'b0, 1'b0);
                8:        e = mk(3'd4, 32'hBADC_0DE0, 1'b1, 1'b1);
                9, 10:    e = mk(3'd4, 32'hBADC_0DE0, 1'b0, 1'b0);
                11:       e = mk(3'd1, word(2'd1), 1'b1, 1'b0);
                default:  e = mk(3'd1, word(2'd1), 1'b0, 1'b0);
            endcase
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL alert_freeze cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
        bus.freeze = 1'b0;
    endtask

    task automatic test_alert_vs_page();
        exp_t e;
        apply_reset(4'b1111, 1'b1);
        bus.alert_data = 32'hCAFE_F00D;
        for (int k = 1; k <= 8; k++) begin
            bus.page_next = (k == 3);
            bus.alert_req = (k >= 3 && k <= 6);
            case (k)
                1:          e = mk(3'd0, word(2'd0), 1'b1, 1'b0);
                2:          e = mk(3'd0, word(2'd0), 1'b0, 1'b0);
                3:          e = mk(3'd4, 32'hCAFE_F00D, 1'b1, 1'b1);
                4, 5, 6:    e = mk(3'd4, 32'hCAFE_F00D, 1'b0, 1'b0);
                7:          e = mk(3'd0, word(2'd0), 1'b1, 1'b0);
                default:    e = mk(3'd0, word(2'd0), 1'b0, 1'b0);
            endcase
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL alert_vs_page cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
        bus.page_next = 1'b0;
        bus.alert_req = 1'b0;
    endtask

    task automatic test_reset_mid_alert();
        exp_t e;
        apply_reset(4'b1111, 1'b0);
        bus.alert_data = 32'h0BAD_F00D;
        tick();
        tick();
        bus.alert_req = 1'b1;
        tick();
        // Alert just entered: ack is high, so an async clear is observable on every output.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !== {3'd7, 32'd0, 2'b00})
        begin
            errors++;
            $display("FAIL reset_async: got src=%0d data=%h upd=%b ack=%b, want src=7 data=0 upd=0 ack=0",
                     bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack);
        end
        bus.alert_req = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            e = mk((k >= 5) ? 3'd1 : 3'd0, (k >= 5) ? word(2'd1) : word(2'd0),
                   k == 1 || k == 5, 1'b0);
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack} !==
                {e.src, e.data, e.upd, e.ack}) begin
                errors++;
                $display("FAIL reset_restart cyc%0d: got src=%0d data=%h upd=%b ack=%b, want src=%0d data=%h upd=%b ack=%b",
                         k, bus.disp_src, bus.disp_data, bus.disp_upd, bus.alert_ack,
                         e.src, e.data, e.upd, e.ack);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_auto_rotate();
        test_manual_paging();
        test_live_data();
        test_alert_freeze();
        test_alert_vs_page();
        test_reset_mid_alert();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
